gpio_cmd_ctrl: RTL and testbench
================================

GPIO_CMD_CTRL -- requirements
Module: gpio_cmd_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  NB_GPIO 32 GPIO word width; NB_OPC 3 opcode width; NB_KDATA 24 kernel row width; N_KROWS 3 kernel rows per kernel;
  NB_LEN 10 image length width; NB_PIX 8 pixel width; NB_RDATA 13 readback width; legal only if NB_GPIO >= NB_RDATA+4 and NB_GPIO-NB_OPC >= NB_KDATA.
REQ-002 Ports (name direction width meaning), one per line:
  i_CLK in 1 clock; i_rst in 1 reset;
  i_GPIOdata in NB_GPIO command word, opcode = top NB_OPC bits, payload = low bits; i_GPIOvalid in 1 command strobe (level);
  i_MCUdata in NB_RDATA result-memory read data; i_EOP in 1 end-of-processing from FSM;
  o_GPIOdata out NB_GPIO status/readback; o_KNLdata out NB_KDATA kernel row; o_KNLrow out clog2(N_KROWS) row index; o_KNLvalid out 1 row strobe;
  o_PIXdata out NB_PIX pixel; o_PIXvalid out 1 pixel strobe; o_imgLength out NB_LEN; o_load out 1; o_run out 1; o_req out 1 read request strobe; o_err out 1 sticky error.
REQ-003 Reset i_rst, synchronous, active-high; clock i_CLK; all state changes on rising i_CLK.

Function
REQ-004 A command SHALL be accepted only in a cycle where i_GPIOvalid=1 and its registered previous value=0 (rising edge); a held level is one command.
REQ-005 Opcodes: 0 KNL_LOAD, 1 SIZE_LOAD, 2 IMG_LOAD, 3 DATA_REQ, 4 GO_RUN, 5 CLEAR, 6-7 illegal.
REQ-006 FSM states IDLE(00), LOAD(01), RUN(10), DONE(11); all outputs registered; effect of an accepted command visible the cycle after acceptance.
REQ-007 KNL_LOAD in IDLE/DONE: o_KNLdata<=payload[NB_KDATA-1:0], o_KNLrow<=row counter, o_KNLvalid 1-cycle pulse, counter increments and wraps N_KROWS-1 -> 0; sticky kernel_full set when row N_KROWS-1 written; DONE -> IDLE.
REQ-008 SIZE_LOAD in IDLE/DONE: o_imgLength<=payload[NB_LEN-1:0]; DONE -> IDLE.
REQ-009 IMG_LOAD in IDLE/DONE/LOAD: o_PIXdata<=payload[NB_PIX-1:0], o_PIXvalid 1-cycle pulse; IDLE/DONE -> LOAD; o_load=1 exactly while in LOAD.
REQ-010 GO_RUN in LOAD: if kernel_full=1 and o_imgLength!=0 -> RUN (o_load=0, o_run=1); otherwise o_err<=1 and stay LOAD.
REQ-011 RUN: i_EOP=1 -> DONE, o_run=0 next cycle; every command except CLEAR ignored without error.
REQ-012 DATA_REQ in DONE: o_req 1-cycle pulse at t+1; readback register <= i_MCUdata at t+2; DATA_REQ in any other state sets o_err.
REQ-013 CLEAR in any state: -> IDLE, row counter=0, kernel_full=0, o_err=0, o_load=o_run=0; o_imgLength and o_KNLdata retained.
REQ-014 Illegal opcode, or KNL_LOAD/SIZE_LOAD in LOAD, SHALL set o_err (sticky) with no other effect.
REQ-015 o_GPIOdata = {done(state==DONE), state[1:0], o_err, zeros, readback[NB_RDATA-1:0]}, MSB first.
REQ-016 i_EOP outside RUN ignored; CLEAR accepted in the same cycle as i_EOP in RUN wins (-> IDLE).
REQ-017 Strobes o_KNLvalid, o_PIXvalid, o_req SHALL be 0 in every cycle not following an accepted matching command.

Reset
REQ-018 On i_rst=1: state IDLE, all outputs 0, row counter 0, kernel_full 0, readback 0, previous-valid register 0; applies mid-RUN and overrides any same-cycle command or i_EOP.
REQ-019 A valid edge whose first cycle coincides with i_rst SHALL be discarded (no command after reset release until a new edge).

Verification
REQ-020 Reset, then 3x KNL_LOAD (0x111111,0x222222,0x333333) -> o_KNLvalid pulses rows 0,1,2 with those data; 4th KNL_LOAD writes row 0 (wrap).
REQ-021 SIZE_LOAD 640, IMG_LOAD 0xAB, GO_RUN -> o_imgLength=640, o_PIXvalid pulse with 0xAB, o_load 1 then 0, o_run=1, o_GPIOdata[NB_GPIO-2:NB_GPIO-3]=10.
REQ-022 GO_RUN with only 2 kernel rows or length 0 -> o_err=1, state stays LOAD, o_run=0; CLEAR -> o_err=0, IDLE.
REQ-023 In RUN pulse i_EOP -> o_run=0, o_GPIOdata MSB=1; DATA_REQ with i_MCUdata=0x1ABC -> o_req pulse at t+1, o_GPIOdata[12:0]=0x1ABC from t+2.
REQ-024 i_GPIOvalid held high 10 cycles with KNL_LOAD -> exactly one o_KNLvalid; opcode 7 -> o_err=1; i_rst asserted in RUN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/gpio_cmd_ctrl.sv
// gpio_cmd_ctrl
// Decodes GPIO command words from a microcontroller and drives the kernel,
// pixel and control interfaces of the convolution engine. It also returns
// a status/readback word on o_GPIOdata.
//
// Command handshake: the bus has no ready signal. i_GPIOvalid is a level.
// A command is taken only on its rising edge, meaning i_GPIOvalid is 1 now
// and was 0 in the previous cycle. A level held high is a single command.
// A level that is already high while i_rst is asserted never counts as an
// edge. It must drop low and rise again before it is taken.
// The effect of a command is visible in the cycle after it is taken.
module gpio_cmd_ctrl #(
    parameter int NB_GPIO  = 32,
    parameter int NB_OPC   = 3,
    parameter int NB_KDATA = 24,
    parameter int N_KROWS  = 3,
    parameter int NB_LEN   = 10,
    parameter int NB_PIX   = 8,
    parameter int NB_RDATA = 13,
    localparam int NB_ROW  = (N_KROWS > 1) ? $clog2(N_KROWS) : 1
) (
    input  logic                i_CLK,
    input  logic                i_rst,
    input  logic [NB_GPIO-1:0]  i_GPIOdata,
    input  logic                i_GPIOvalid,
    input  logic [NB_RDATA-1:0] i_MCUdata,
    input  logic                i_EOP,
    output logic [NB_GPIO-1:0]  o_GPIOdata,
    output logic [NB_KDATA-1:0] o_KNLdata,
    output logic [NB_ROW-1:0]   o_KNLrow,
    output logic                o_KNLvalid,
    output logic [NB_PIX-1:0]   o_PIXdata,
    output logic                o_PIXvalid,
    output logic [NB_LEN-1:0]   o_imgLength,
    output logic                o_load,
    output logic                o_run,
    output logic                o_req,
    output logic                o_err
);

    // Opcodes
    localparam logic [NB_OPC-1:0] OPC_KNL   = NB_OPC'(0);
    localparam logic [NB_OPC-1:0] OPC_SIZE  = NB_OPC'(1);
    localparam logic [NB_OPC-1:0] OPC_IMG   = NB_OPC'(2);
    localparam logic [NB_OPC-1:0] OPC_REQ   = NB_OPC'(3);
    localparam logic [NB_OPC-1:0] OPC_GO    = NB_OPC'(4);
    localparam logic [NB_OPC-1:0] OPC_CLEAR = NB_OPC'(5);

    // Controller states; the encoding is reported on o_GPIOdata
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_LOAD = 2'b01;
    localparam logic [1:0] S_RUN  = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    localparam logic [NB_ROW-1:0] ROW_LAST = NB_ROW'(N_KROWS - 1);

    logic [1:0]          state;
    logic [1:0]          state_nx;
    logic                valid_q;
    logic                hold_q;
    logic                accept;
    logic [NB_OPC-1:0]   opc;
    logic [NB_ROW-1:0]   row_cnt;
    logic                kernel_full;
    logic [NB_RDATA-1:0] readback;

    logic do_knl;
    logic do_size;
    logic do_img;
    logic do_req;
    logic do_clear;
    logic err_set;

    // Only the opcode and the payload fields carry meaning. The bits between
    // them are folded into this signal so that they are still consumed.
    logic unused_gpio_bits;
    assign unused_gpio_bits = ^i_GPIOdata;

    assign opc    = i_GPIOdata[NB_GPIO-1 -: NB_OPC];
    assign accept = i_GPIOvalid & ~valid_q & ~hold_q;

    // Rising-edge detector for the command strobe.
    // During reset, hold_q records whether the level is already high, so that
    // level is not taken as a fresh edge once reset is released.
    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            hold_q  <= i_GPIOvalid;
        end else begin
            valid_q <= i_GPIOvalid;
            if (!i_GPIOvalid) begin
                hold_q <= 1'b0;
            end
        end
    end

    // Command decode and next-state selection
    always_comb begin
        state_nx = state;
        do_knl   = 1'b0;
        do_size  = 1'b0;
        do_img   = 1'b0;
        do_req   = 1'b0;
        do_clear = 1'b0;
        err_set  = 1'b0;
        if (state == S_RUN) begin
            // While running, only CLEAR is honoured. CLEAR beats a same-cycle EOP.
            if (accept && (opc == OPC_CLEAR)) begin
                do_clear = 1'b1;
                state_nx = S_IDLE;
            end else if (i_EOP) begin
                state_nx = S_DONE;
            end
        end else if (accept) begin
            case (opc)
                OPC_KNL: begin
                    if (state == S_LOAD) begin
                        err_set = 1'b1;
                    end else begin
                        do_knl   = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
                OPC_SIZE: begin
                    if (state == S_LOAD) begin
                        err_set = 1'b1;
                    end else begin
                        do_size  = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
                OPC_IMG: begin
                    do_img   = 1'b1;
                    state_nx = S_LOAD;
                end
                OPC_REQ: begin
                    if (state == S_DONE) begin
                        do_req = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                OPC_GO: begin
                    // A run starts only from LOAD, with a full kernel and a nonzero length
                    if ((state == S_LOAD) && kernel_full && (o_imgLength != '0)) begin
                        state_nx = S_RUN;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                OPC_CLEAR: begin
                    do_clear = 1'b1;
                    state_nx = S_IDLE;
                end
                default: begin
                    err_set = 1'b1;
                end
            endcase
        end
    end

    // State register and the control levels decoded from the next state
    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            state  <= S_IDLE;
            o_load <= 1'b0;
            o_run  <= 1'b0;
        end else begin
            state  <= state_nx;
            o_load <= (state_nx == S_LOAD);
            o_run  <= (state_nx == S_RUN);
        end
    end

    // Kernel row writes: row counter wraps, kernel_full latches on last row
    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            o_KNLdata   <= '0;
            o_KNLrow    <= '0;
            o_KNLvalid  <= 1'b0;
            row_cnt     <= '0;
            kernel_full <= 1'b0;
        end else begin
            o_KNLvalid <= do_knl;
            if (do_clear) begin
                row_cnt     <= '0;
                kernel_full <= 1'b0;
            end else if (do_knl) begin
                o_KNLdata <= i_GPIOdata[NB_KDATA-1:0];
                o_KNLrow  <= row_cnt;
                if (row_cnt == ROW_LAST) begin
                    row_cnt     <= '0;
                    kernel_full <= 1'b1;
                end else begin
                    row_cnt <= row_cnt + 1'b1;
                end
            end
        end
    end

    // Image length and pixel stream registers
    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            o_imgLength <= '0;
            o_PIXdata   <= '0;
            o_PIXvalid  <= 1'b0;
        end else begin
            o_PIXvalid <= do_img;
            if (do_size) begin
                o_imgLength <= i_GPIOdata[NB_LEN-1:0];
            end
            if (do_img) begin
                o_PIXdata <= i_GPIOdata[NB_PIX-1:0];
            end
        end
    end

    // Result read: request pulse, then capture memory data one cycle later
    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            o_req    <= 1'b0;
            readback <= '0;
        end else begin
            o_req <= do_req;
            if (o_req) begin
                readback <= i_MCUdata;
            end
        end
    end

    // Sticky error flag; only CLEAR or reset removes it
    always_ff @(posedge i_CLK) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else if (do_clear) begin
            o_err <= 1'b0;
        end else if (err_set) begin
            o_err <= 1'b1;
        end
    end

    // Status word: {done, state, err, zero fill, readback}, MSB first
    always_comb begin
        o_GPIOdata                 = '0;
        o_GPIOdata[NB_RDATA-1:0]   = readback;
        o_GPIOdata[NB_GPIO-4]      = o_err;
        o_GPIOdata[NB_GPIO-3 +: 2] = state;
        o_GPIOdata[NB_GPIO-1]      = (state == S_DONE);
    end

endmodule

// File: tb/tb_gpio_cmd_ctrl.sv
// tb_gpio_cmd_ctrl
// Runs directed scenarios and then randomized command traffic against
// gpio_cmd_ctrl. A behavioural reference model predicts every output on
// every clock cycle.
module tb_gpio_cmd_ctrl;

    localparam int NB_GPIO  = 32;
    localparam int NB_KDATA = 24;
    localparam int NB_LEN   = 10;
    localparam int NB_PIX   = 8;
    localparam int NB_RDATA = 13;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_DONE = 3;

    logic                i_CLK;
    logic                i_rst;
    logic [NB_GPIO-1:0]  i_GPIOdata;
    logic                i_GPIOvalid;
    logic [NB_RDATA-1:0] i_MCUdata;
    logic                i_EOP;
    logic [NB_GPIO-1:0]  o_GPIOdata;
    logic [NB_KDATA-1:0] o_KNLdata;
    logic [1:0]          o_KNLrow;
    logic                o_KNLvalid;
    logic [NB_PIX-1:0]   o_PIXdata;
    logic                o_PIXvalid;
    logic [NB_LEN-1:0]   o_imgLength;
    logic                o_load;
    logic                o_run;
    logic                o_req;
    logic                o_err;

    gpio_cmd_ctrl dut (
        .i_CLK       (i_CLK),
        .i_rst       (i_rst),
        .i_GPIOdata  (i_GPIOdata),
        .i_GPIOvalid (i_GPIOvalid),
        .i_MCUdata   (i_MCUdata),
        .i_EOP       (i_EOP),
        .o_GPIOdata  (o_GPIOdata),
        .o_KNLdata   (o_KNLdata),
        .o_KNLrow    (o_KNLrow),
        .o_KNLvalid  (o_KNLvalid),
        .o_PIXdata   (o_PIXdata),
        .o_PIXvalid  (o_PIXvalid),
        .o_imgLength (o_imgLength),
        .o_load      (o_load),
        .o_run       (o_run),
        .o_req       (o_req),
        .o_err       (o_err)
    );

    // Clock
    initial i_CLK = 1'b0;
    always #5 i_CLK = ~i_CLK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    // Reference model state
    int          m_mode;
    bit          m_prev, m_hold;
    int          m_knl_cnt;   // kernel rows loaded since the last clear/reset
    bit          m_err;
    logic [31:0] m_len, m_kdata, m_krow, m_pd, m_rb;
    bit          m_kv, m_pv, m_req;

    task automatic m_clear();
        m_mode    = M_IDLE;
        m_knl_cnt = 0;
        m_err     = 0;
    endtask

    // Applies the inputs present at this rising edge to the model
    task automatic model_step();
        bit acc;
        int opc;
        if (i_rst) begin
            m_mode = M_IDLE; m_prev = 0; m_hold = i_GPIOvalid; m_knl_cnt = 0;
            m_err = 0; m_len = 0; m_kdata = 0; m_krow = 0; m_pd = 0; m_rb = 0;
            m_kv = 0; m_pv = 0; m_req = 0;
            return;
        end
        acc = i_GPIOvalid && !m_prev && !m_hold;
        m_prev = i_GPIOvalid;
        if (!i_GPIOvalid) m_hold = 0;
        opc = int'(i_GPIOdata[31:29]);
        if (m_req) m_rb = 32'(i_MCUdata);
        m_kv = 0; m_pv = 0; m_req = 0;
        if (m_mode == M_RUN) begin
            if (acc && opc == 5) m_clear();
            else if (i_EOP) m_mode = M_DONE;
        end else if (acc) begin
            case (opc)
                0: if (m_mode == M_LOAD) m_err = 1;
                   else begin
                       m_kdata = 32'(i_GPIOdata[23:0]);
                       m_krow  = m_knl_cnt % 3;
                       m_kv    = 1;
                       m_knl_cnt++;
                       m_mode  = M_IDLE;
                   end
                1: if (m_mode == M_LOAD) m_err = 1;
                   else begin
                       m_len  = 32'(i_GPIOdata[9:0]);
                       m_mode = M_IDLE;
                   end
                2: begin
                       m_pd   = 32'(i_GPIOdata[7:0]);
                       m_pv   = 1;
                       m_mode = M_LOAD;
                   end
                3: if (m_mode == M_DONE) m_req = 1; else m_err = 1;
                4: if (m_mode == M_LOAD && m_knl_cnt >= 3 && m_len != 0) m_mode = M_RUN;
                   else m_err = 1;
                5: m_clear();
                default: m_err = 1;
            endcase
        end
    endtask

    // One clock: advance the model at the edge, compare all outputs 1 time unit later
    task automatic cycle();
        logic [31:0] exp_gpio;
        @(posedge i_CLK);
        model_step();
        #1;
        exp_gpio = ((m_mode == M_DONE) ? 32'h8000_0000 : 32'h0) + (m_mode * 32'h2000_0000)
                 + (m_err ? 32'h1000_0000 : 32'h0) + m_rb;
        check("gpio",    o_GPIOdata, exp_gpio);
        check("knl_vld", 32'(o_KNLvalid), 32'(m_kv));
        check("knl_dat", 32'(o_KNLdata), m_kdata);
        check("knl_row", 32'(o_KNLrow), m_krow);
        check("pix_vld", 32'(o_PIXvalid), 32'(m_pv));
        check("pix_dat", 32'(o_PIXdata), m_pd);
        check("img_len", 32'(o_imgLength), m_len);
        check("load",    32'(o_load), 32'(m_mode == M_LOAD));
        check("run",     32'(o_run), 32'(m_mode == M_RUN));
        check("req",     32'(o_req), 32'(m_req));
        check("err",     32'(o_err), 32'(m_err));
    endtask

    task automatic idle();
        i_GPIOvalid = 0;
        cycle();
    endtask

    // One command: a low cycle, then a single-cycle strobe. On return, the
    // outputs show the effect of the command.
    task automatic cmd(input int opc, input int payload);
        logic [31:0] o, p;
        o = 32'(opc);
        p = 32'(payload);
        i_GPIOvalid = 0;
        cycle();
        i_GPIOdata  = {o[2:0], p[28:0]};
        i_GPIOvalid = 1;
        cycle();
        i_GPIOvalid = 0;
    endtask

    task automatic setup_run();
        cmd(5, 0);
        cmd(0, 'h0A0A0A); cmd(0, 'h0B0B0B); cmd(0, 'h0C0C0C);
        cmd(1, 100);
        cmd(2, 'h55);
        cmd(4, 0);
    endtask

    int pulses;

    initial begin
        i_rst = 1; i_GPIOdata = '0; i_GPIOvalid = 0; i_MCUdata = '0; i_EOP = 0;
        cycle(); cycle();
        check("rst_gpio", o_GPIOdata, 32'h0);
        check("rst_len",  32'(o_imgLength), 32'h0);
        i_rst = 0;
        idle();

        // Kernel rows, including the wrap back to row 0
        cmd(0, 'h111111); check("k0_row", 32'(o_KNLrow), 0); check("k0_dat", 32'(o_KNLdata), 'h111111);
        cmd(0, 'h222222); check("k1_row", 32'(o_KNLrow), 1); check("k1_dat", 32'(o_KNLdata), 'h222222);
        cmd(0, 'h333333); check("k2_row", 32'(o_KNLrow), 2); check("k2_dat", 32'(o_KNLdata), 'h333333);
        cmd(0, 'h444444); check("k3_wrap", 32'(o_KNLrow), 0); check("k3_vld", 32'(o_KNLvalid), 1);

        // Size, pixel, run
        cmd(1, 640);  check("len640", 32'(o_imgLength), 640);
        cmd(2, 'hAB); check("pix_ab", 32'(o_PIXdata), 'hAB); check("load_on", 32'(o_load), 1);
        cmd(4, 0);    check("run_on", 32'(o_run), 1); check("load_off", 32'(o_load), 0);
        check("st_run", 32'(o_GPIOdata[30:29]), 2);

        // End of processing, then result readback
        i_EOP = 1; cycle(); i_EOP = 0;
        check("eop_run", 32'(o_run), 0); check("done_bit", 32'(o_GPIOdata[31]), 1);
        i_MCUdata = 13'h1ABC;
        cmd(3, 0); check("req_t1", 32'(o_req), 1);
        idle();    check("req_t2", 32'(o_req), 0); check("rdback", 32'(o_GPIOdata[12:0]), 'h1ABC);

        // Run refused with only two kernel rows
        cmd(5, 0);
        cmd(0, 1); cmd(0, 2); cmd(1, 5); cmd(2, 1); cmd(4, 0);
        check("go2_err", 32'(o_err), 1); check("go2_st", 32'(o_GPIOdata[30:29]), 1);
        check("go2_run", 32'(o_run), 0);
        cmd(5, 0); check("clr_err", 32'(o_err), 0); check("clr_st", 32'(o_GPIOdata[30:29]), 0);

        // Run refused with zero length
        cmd(0, 1); cmd(0, 2); cmd(0, 3); cmd(1, 0); cmd(2, 1); cmd(4, 0);
        check("go0_err", 32'(o_err), 1); check("go0_run", 32'(o_run), 0);
        cmd(5, 0);

        // A held level counts as one command
        idle();
        i_GPIOdata = {3'd0, 29'h0777777}; i_GPIOvalid = 1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin cycle(); pulses += int'(o_KNLvalid); end
        check("held_one", 32'(pulses), 1);
        i_GPIOvalid = 0;

        cmd(7, 0); check("illegal", 32'(o_err), 1);

        // Reset in the middle of a run
        setup_run(); check("pre_run", 32'(o_run), 1);
        i_rst = 1; cycle();
        check("rr_gpio", o_GPIOdata, 0); check("rr_run", 32'(o_run), 0);
        check("rr_knl", 32'(o_KNLdata), 0); check("rr_len", 32'(o_imgLength), 0);

        // Edge during reset is dropped
        i_GPIOdata = {3'd0, 29'h0123456}; i_GPIOvalid = 1; cycle();
        i_rst = 0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin cycle(); pulses += int'(o_KNLvalid); end
        check("rst_edge", 32'(pulses), 0);
        i_GPIOvalid = 0;
        idle();

        // Randomized traffic checked cycle by cycle against the model
        for (int n = 0; n < 300; n++) begin
            int r, opc, hold, gap;
            logic [31:0] pl, o;
            r = $urandom_range(0, 99);
            opc = (r < 30) ? 0 : (r < 40) ? 1 : (r < 58) ? 2 : (r < 68) ? 3 :
                  (r < 85) ? 4 : (r < 91) ? 5 : $urandom_range(6, 7);
            pl = $urandom;
            if (opc == 1 && $urandom_range(0, 7) == 0) pl = 0;
            o = 32'(opc);
            hold = $urandom_range(1, 3);
            gap  = $urandom_range(1, 3);
            i_GPIOdata = {o[2:0], pl[28:0]};
            for (int c = 0; c < hold + gap; c++) begin
                i_GPIOvalid = (c < hold);
                i_EOP       = ($urandom_range(0, 5) == 0);
                i_MCUdata   = 13'($urandom_range(0, 8191));
                i_rst       = ($urandom_range(0, 199) == 0);
                cycle();
            end
        end
        i_rst = 0; i_EOP = 0; i_GPIOvalid = 0;
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
